// File: rtl/truth_table_sequencer_if.sv
// Interface bundling the sequencer's control, gate-drive and result signals.
// The optional reference compare (macro TT_CHECK_EN) adds expected/mismatch.
// slave  : the sequencer itself.
// master : the controller together with the gate under characterisation.
interface truth_table_sequencer_if #(
   parameter int N_IN = 3
);
   localparam int TW = 1 << N_IN;

   logic            start;
   logic            abort;
   logic [N_IN-1:0] dut_in;
   logic            dut_out;
   logic            busy;
   logic            done;
   logic [TW-1:0]   tt;
`ifdef TT_CHECK_EN
   logic [TW-1:0]   expected;
   logic            mismatch;

   modport slave  (input  start, abort, dut_out, expected,
                   output dut_in, busy, done, tt, mismatch);
   modport master (output start, abort, dut_out, expected,
                   input  dut_in, busy, done, tt, mismatch);
`else
   modport slave  (input  start, abort, dut_out,
                   output dut_in, busy, done, tt);
   modport master (output start, abort, dut_out,
                   input  dut_in, busy, done, tt);
`endif
endinterface

// File: rtl/truth_table_sequencer.sv
// Truth-table sequencer: sweeps an N_IN-input gate through every input vector,
// holds each vector SETTLE cycles, samples the gate output and builds tt.
// Optional feature macro: TT_CHECK_EN (adds expected/mismatch compare).
module truth_table_sequencer #(
   parameter int N_IN   = 3,
   parameter int SETTLE = 16,
   parameter int CW     = 8
) (
   input logic                    clk,
   input logic                    rst,
   truth_table_sequencer_if.slave bus
);
   localparam int TW = 1 << N_IN;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_SAMPLE = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

   localparam logic [CW-1:0]   CNT_LOAD = CW'(SETTLE - 1);
   localparam logic [N_IN-1:0] IDX_LAST = '1;

   if (SETTLE < 1 || SETTLE > (1 << CW) - 1) begin : g_settle_range
      $error("truth_table_sequencer: SETTLE must lie in 1..2**CW-1");
   end

   logic [1:0]      state;
   logic [N_IN-1:0] idx;
   logic [CW-1:0]   cnt;
   logic [N_IN-1:0] dut_in_r;
   logic [TW-1:0]   tt_r;

   // Sweep FSM: vector index, settle counter, registered gate drive and table.
   // Abort is checked before sampling so an aborted SAMPLE leaves tt untouched.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         idx      <= '0;
         cnt      <= '0;
         dut_in_r <= '0;
         tt_r     <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.start && !bus.abort) begin
                  state    <= ST_SETTLE;
                  idx      <= '0;
                  dut_in_r <= '0;
                  cnt      <= CNT_LOAD;
                  tt_r     <= '0;
               end
            end
            ST_SETTLE: begin
               if (bus.abort) begin
                  state    <= ST_IDLE;
                  dut_in_r <= '0;
               end else if (cnt == '0) begin
                  state <= ST_SAMPLE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_SAMPLE: begin
               if (bus.abort) begin
                  state    <= ST_IDLE;
                  dut_in_r <= '0;
               end else begin
                  tt_r[idx] <= bus.dut_out;
                  if (idx == IDX_LAST) begin
                     state    <= ST_DONE;
                     dut_in_r <= '0;
                  end else begin
                     idx      <= idx + 1'b1;
                     dut_in_r <= idx + 1'b1;
                     cnt      <= CNT_LOAD;
                     state    <= ST_SETTLE;
                  end
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Status outputs decoded straight from the state register.
   assign bus.busy   = (state == ST_SETTLE) || (state == ST_SAMPLE);
   assign bus.done   = (state == ST_DONE);
   assign bus.dut_in = dut_in_r;
   assign bus.tt     = tt_r;

`ifdef TT_CHECK_EN
   logic mismatch_r;

   // Reference compare: captured in the DONE cycle, cleared by a new sweep.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mismatch_r <= 1'b0;
      end else if (state == ST_IDLE && bus.start && !bus.abort) begin
         mismatch_r <= 1'b0;
      end else if (state == ST_DONE) begin
         mismatch_r <= (tt_r != bus.expected);
      end
   end

   assign bus.mismatch = mismatch_r;
`endif

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Self-checking bench for truth_table_sequencer (N_IN=3, SETTLE=16).
// The gate is modelled as an 8-entry lookup table indexed by dut_in; expected
// tables are queued when a sweep starts and compared when done pulses.
module tb_truth_table_sequencer;
   localparam int N_IN   = 3;
   localparam int SETTLE = 16;
   localparam int CW     = 8;
   localparam int LAT    = (1 << N_IN) * (SETTLE + 1);

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] gate_tt = 8'h00;
   logic [7:0] exp_q[$];
   int         n_checks = 0;
   int         n_fail = 0;
   int         done_count = 0;

   truth_table_sequencer_if #(.N_IN(N_IN)) bus ();

   truth_table_sequencer #(
      .N_IN  (N_IN),
      .SETTLE(SETTLE),
      .CW    (CW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   assign bus.dut_out = gate_tt[bus.dut_in];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Scoreboard: every done pulse must match the next queued table.
   always @(negedge clk) begin
      if (bus.done === 1'b1) begin
         done_count++;
         if (exp_q.size() == 0) begin
            check_eq("unexpected_done", 32'd1, 32'd0);
         end else begin
            check_eq("tt", bus.tt, exp_q.pop_front());
         end
      end
   end

   // mode 0: plain, 1: trace dut_in/busy each cycle, 2: re-pulse start,
   // 3: abort after edge 50, 4: async reset after edge 60
   task automatic run_sweep(input logic [7:0] gate, input int mode, input logic [7:0] exp_tt);
      int  dc0;
      bit  seen;
      gate_tt = gate;
      if (mode <= 2) exp_q.push_back(exp_tt);
      dc0 = done_count;
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      check_eq("busy_after_start", bus.busy, 1);
      check_eq("dut_in_first", bus.dut_in, 0);
      seen = 1'b0;
      for (int k = 1; k <= LAT + 64; k++) begin
         @(posedge clk); #1;
         bus.start = (mode == 2 && (k == 10 || k == 80));
         if (mode == 3 && k == 50) bus.abort = 1'b1;
         if (mode == 3 && k == 51) begin
            bus.abort = 1'b0;
            check_eq("abort_busy", bus.busy, 0);
            check_eq("abort_dut_in", bus.dut_in, 0);
            repeat (150) @(posedge clk);
            #1;
            check_eq("abort_no_done", done_count, dc0);
            check_eq("abort_tt", bus.tt, exp_tt);
            check_eq("abort_idle", bus.busy, 0);
            return;
         end
         if (mode == 4 && k == 60) begin
            #3 rst = 1'b1;
            #1;
            check_eq("rst_busy", bus.busy, 0);
            check_eq("rst_done", bus.done, 0);
            check_eq("rst_dut_in", bus.dut_in, 0);
            check_eq("rst_tt", bus.tt, 0);
            #2 rst = 1'b0;
            repeat (5) @(posedge clk);
            #1;
            check_eq("rst_no_done", done_count, dc0);
            check_eq("rst_idle", bus.busy, 0);
            return;
         end
         if (mode == 1 && k < LAT) begin
            check_eq("trace_dut_in", bus.dut_in, k / (SETTLE + 1));
            check_eq("trace_busy", bus.busy, 1);
         end
         if (bus.done === 1'b1) begin
            seen = 1'b1;
            check_eq("done_latency", k, LAT);
            check_eq("done_dut_in", bus.dut_in, 0);
            check_eq("done_busy", bus.busy, 0);
            break;
         end
      end
      if (!seen) check_eq("done_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      check_eq("done_single", bus.done, 0);
      check_eq("idle_busy", bus.busy, 0);
      check_eq("hold_tt", bus.tt, exp_tt);
`ifdef TT_CHECK_EN
      check_eq("mismatch", bus.mismatch, (exp_tt != bus.expected) ? 32'd1 : 32'd0);
`endif
   endtask

   initial begin
      bus.start = 1'b0;
      bus.abort = 1'b0;
`ifdef TT_CHECK_EN
      bus.expected = 8'h40;
`endif
      repeat (3) @(posedge clk);
      #1;
      check_eq("reset_busy", bus.busy, 0);
      check_eq("reset_done", bus.done, 0);
      check_eq("reset_dut_in", bus.dut_in, 0);
      check_eq("reset_tt", bus.tt, 0);
`ifdef TT_CHECK_EN
      check_eq("reset_mismatch", bus.mismatch, 0);
`endif
      @(negedge clk);
      rst = 1'b0;

      run_sweep(8'h40, 1, 8'h40);   // gate active only for 3'b110
      run_sweep(8'hFF, 0, 8'hFF);
      run_sweep(8'h00, 0, 8'h00);
      run_sweep(8'h5A, 0, 8'h5A);
      run_sweep(8'h40, 3, 8'h00);   // abort before vector 6 is reached
      run_sweep(8'hFF, 3, 8'h03);   // vectors 0,1 sampled, vector 2 aborted
      run_sweep(8'h40, 2, 8'h40);   // start pulses mid-sweep ignored

      // start and abort together in IDLE: must stay idle
      @(negedge clk);
      bus.start = 1'b1;
      bus.abort = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      bus.abort = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("start_abort_idle", bus.busy, 0);

      run_sweep(8'hFF, 4, 8'h00);   // async reset mid-sweep
      run_sweep(8'h40, 0, 8'h40);   // fresh sweep after reset
`ifdef TT_CHECK_EN
      run_sweep(8'h42, 0, 8'h42);
      run_sweep(8'h40, 0, 8'h40);
`endif
      repeat (4) @(posedge clk);
      #1;
      check_eq("scoreboard_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
